// File: rtl/exp_out_buffer.sv
// Purpose: converts Q7.25 exponential results to Q2.14 (round-to-nearest, saturating) into an FWFT FIFO.
// Latency: a push is visible at the head one cycle later when empty; otherwise it waits behind older entries.
// Backpressure: o_ready drops only when the FIFO is full; it comes from registered count, never from i_ready.
module exp_out_buffer #(
    parameter int DEPTH    = 8,
    parameter int WIDTHIN  = 32,
    parameter int WIDTHOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    input  logic [WIDTHIN-1:0]         i_y,
    output logic                       o_ready,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTHOUT-1:0]        o_q,
    output logic                       o_sat,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [15:0]                o_sat_count
);

    localparam int PW        = $clog2(DEPTH);
    localparam int CW        = PW + 1;
    // Fraction bits discarded: Q7.25 -> Q2.14 drops 25-14 = 11 LSBs.
    localparam int FRAC_DROP = (WIDTHIN - 7) - (WIDTHOUT - 2);
    // Input bits at or above this position exceed the Q2.14 integer range.
    localparam int INT_LSB   = FRAC_DROP + WIDTHOUT;

    logic [WIDTHOUT:0]   mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [15:0]         sat_count;

    logic [WIDTHOUT-1:0] trunc_val;
    logic                rnd_bit;
    logic                cvt_sat;
    logic [WIDTHOUT-1:0] cvt_q;
    logic                push;
    logic                pop;
    logic [WIDTHOUT:0]   head;

    // Round-to-nearest conversion; saturate on integer overflow or when rounding would carry out.
    always_comb begin
        trunc_val = i_y[INT_LSB-1:FRAC_DROP];
        rnd_bit   = i_y[FRAC_DROP-1];
        cvt_sat   = (|i_y[WIDTHIN-1:INT_LSB]) | ((&trunc_val) & rnd_bit);
        cvt_q     = cvt_sat ? '1 : trunc_val + WIDTHOUT'(rnd_bit);
    end

    // o_ready is gated by reset so nothing is accepted while reset is held.
    assign o_ready     = (count != CW'(DEPTH)) & reset;
    assign o_valid     = (count != '0);
    assign push        = i_valid & o_ready;
    assign pop         = o_valid & i_ready;
    assign head        = mem[rd_ptr];
    assign o_q         = head[WIDTHOUT-1:0];
    assign o_sat       = head[WIDTHOUT];
    assign o_count     = count;
    assign o_sat_count = sat_count;

    // Storage array is not reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cvt_sat, cvt_q};
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky-at-max tally of saturated results written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_count <= '0;
        end else if (push && cvt_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_exp_out_buffer.sv
// Purpose: self-checking bench for exp_out_buffer with a queue-based reference model.
// Latency: model state is compared one time unit after each rising edge.
// Backpressure: random and directed i_valid / i_ready patterns, including full and reset cases.
module tb_exp_out_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_y;
    logic        o_ready;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_q;
    logic        o_sat;
    logic [3:0]  o_count;
    logic [15:0] o_sat_count;

    exp_out_buffer #(.DEPTH(DEPTH), .WIDTHIN(32), .WIDTHOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .i_y         (i_y),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_q         (o_q),
        .o_sat       (o_sat),
        .o_count     (o_count),
        .o_sat_count (o_sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic [15:0] q;
        logic        sat;
    } vec_t;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [16:0] mq[$];
    int          sat_m   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Value-level reference: y/2^11 rounded half-up; anything that does not fit 16 bits saturates.
    function automatic logic [16:0] conv(input logic [31:0] y);
        logic [63:0] v;
        v = ({32'd0, y} + 64'd1024) >> 11;
        if (v > 64'd65535) return {1'b1, 16'hFFFF};
        return {1'b0, v[15:0]};
    endfunction

    task automatic check_state();
        logic [16:0] h;
        chk("o_valid", {31'd0, o_valid}, {31'd0, mq.size() != 0});
        chk("o_count", {28'd0, o_count}, mq.size());
        chk("o_ready", {31'd0, o_ready}, {31'd0, mq.size() != DEPTH});
        chk("o_sat_count", {16'd0, o_sat_count}, sat_m);
        if (mq.size() != 0) begin
            h = mq[0];
            chk("o_q", {16'd0, o_q}, {16'd0, h[15:0]});
            chk("o_sat", {31'd0, o_sat}, {31'd0, h[16]});
        end
    endtask

    // One clock: compare against model, drive inputs, advance model, step past next edge.
    task automatic cycle(input logic v, input logic [31:0] y, input logic rdy);
        logic        do_push;
        logic        do_pop;
        logic [16:0] c;
        check_state();
        i_valid = v;
        i_y     = y;
        i_ready = rdy;
        do_push = v && (mq.size() < DEPTH);
        do_pop  = rdy && (mq.size() > 0);
        c       = conv(y);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(c);
            if (c[16] && sat_m < 65535) sat_m++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_y();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return r & 32'h07FF_FFFF;
            2:       return 32'h07FF_F800 | (r & 32'h0000_07FF);
            default: return r & 32'h03FF_FFFF;
        endcase
    endfunction

    vec_t tbl[8];

    initial begin
        tbl[0] = '{32'h0200_0400, 16'h4001, 1'b0};
        tbl[1] = '{32'h0800_0000, 16'hFFFF, 1'b1};
        tbl[2] = '{32'h07FF_FC00, 16'hFFFF, 1'b1};
        tbl[3] = '{32'h07FF_F800, 16'hFFFF, 1'b0};
        tbl[4] = '{32'h0000_0000, 16'h0000, 1'b0};
        tbl[5] = '{32'h0000_03FF, 16'h0000, 1'b0};
        tbl[6] = '{32'h0000_0400, 16'h0001, 1'b0};
        tbl[7] = '{32'hFFFF_FFFF, 16'hFFFF, 1'b1};

        reset   = 1'b0;
        i_valid = 1'b0;
        i_y     = '0;
        i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_count", {28'd0, o_count}, 32'd0);
        chk("rst_satcnt", {16'd0, o_sat_count}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rel_ready", {31'd0, o_ready}, 32'd1);

        // Single push of 1.0 with downstream ready.
        cycle(1'b1, 32'h0200_0000, 1'b1);
        chk("one_valid", {31'd0, o_valid}, 32'd1);
        chk("one_q", {16'd0, o_q}, 32'h4000);
        chk("one_sat", {31'd0, o_sat}, 32'd0);
        cycle(1'b0, 32'd0, 1'b1);
        chk("one_drained", {28'd0, o_count}, 32'd0);

        // Conversion table, pushed back-to-back with downstream stalled.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tbl[i].y, 1'b0);
            if (i == 3) chk("tbl_satcnt4", {16'd0, o_sat_count}, 32'd2);
        end
        chk("tbl_full_cnt", {28'd0, o_count}, 32'd8);
        chk("tbl_full_rdy", {31'd0, o_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("tbl_q", {16'd0, o_q}, {16'd0, tbl[i].q});
            chk("tbl_sat", {31'd0, o_sat}, {31'd0, tbl[i].sat});
            cycle(1'b0, 32'd0, 1'b1);
        end

        // Fill with 1..9 while stalled; only 8 fit.
        for (int k = 1; k <= 9; k++) begin
            if (k == 9) chk("fill_9th_rdy", {31'd0, o_ready}, 32'd0);
            cycle(1'b1, k << 11, 1'b0);
        end
        chk("fill_cnt", {28'd0, o_count}, 32'd8);
        chk("fill_head", {16'd0, o_q}, 32'd1);
        cycle(1'b0, 32'd0, 1'b1);
        chk("fill_rdy_after_pop", {31'd0, o_ready}, 32'd1);
        chk("fill_cnt_after_pop", {28'd0, o_count}, 32'd7);
        for (int k = 2; k <= 8; k++) begin
            chk("fill_order", {16'd0, o_q}, k);
            cycle(1'b0, 32'd0, 1'b1);
        end
        chk("fill_empty", {31'd0, o_valid}, 32'd0);

        // Streaming with concurrent push/pop, crossing the pointer wrap.
        for (int n = 0; n < 20; n++) begin
            cycle(1'b1, rand_y(), 1'b1);
            chk("stream_cnt_le1", {31'd0, o_count <= 4'd1}, 32'd1);
        end
        cycle(1'b0, 32'd0, 1'b1);
        chk("stream_drained", {28'd0, o_count}, 32'd0);

        // Asynchronous reset in the middle of a cycle with 5 entries held.
        for (int n = 0; n < 5; n++) cycle(1'b1, 32'h0900_0000 + n, 1'b0);
        i_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd0);
        chk("mid_rst_count", {28'd0, o_count}, 32'd0);
        chk("mid_rst_satcnt", {16'd0, o_sat_count}, 32'd0);
        mq.delete();
        sat_m = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
        for (int n = 0; n < 3; n++) cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b1, 32'h0100_0000, 1'b0);
        chk("post_rst_head", {16'd0, o_q}, 32'h2000);
        cycle(1'b0, 32'd0, 1'b1);

        // Random stress against the model.
        for (int n = 0; n < 10000; n++) begin
            cycle($urandom_range(0, 9) < 6, rand_y(), $urandom_range(0, 9) < 5);
        end
        check_state();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exp_out_buffer.md
# exp_out_buffer

Output stage placed directly downstream of the Taylor-series exponential pipeline. Accepts Q7.25 results through a valid/ready handshake and converts each one to Q2.14 with round-to-nearest and saturation. Stores the converted results in a first-word-fall-through FIFO. Drives the pipeline's `i_ready` (this block's `o_ready`) so the upstream pipeline stalls only when the FIFO is full, which isolates it from downstream back-pressure.

## Interface
- `DEPTH`, default 8: FIFO entries; power of 2, ≥2.
- `WIDTHIN`, default 32: input width, Q7.25 unsigned.
- `WIDTHOUT`, default 16: output width, Q2.14 unsigned.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; asserted when 0.
- `i_valid` input 1: upstream result valid.
- `i_y` input WIDTHIN: upstream Q7.25 result.
- `o_ready` output 1: space available; connects to upstream `i_ready`.
- `o_valid` output 1: FIFO head valid.
- `i_ready` input 1: downstream accepts the head.
- `o_q` output WIDTHOUT: head result, Q2.14.
- `o_sat` output 1: head result was saturated.
- `o_count` output $clog2(DEPTH)+1: current occupancy.
- `o_sat_count` output 16: total saturated results written since reset; sticks at 0xFFFF.

## Operation
- push = `i_valid & o_ready`; pop = `o_valid & i_ready`.
- `i_valid` is ignored while `o_ready` = 0, and nothing is written.
- Conversion is combinational on `i_y` and applied at write time. Each entry stores {sat, q}, 17 bits.
  - t = `i_y[26:11]`, r = `i_y[10]`.
  - sat = (`i_y[31:27]` != 0) | (t == 0xFFFF & r).
  - q = sat ? 0xFFFF : t + r.
- Storage: `mem[DEPTH]`, `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits each, wrapping modulo DEPTH, plus `count`.
- On push: `mem[wr_ptr]` is written and `wr_ptr` increments.
- On pop: `rd_ptr` increments.
- `count` update: +1 on push only, −1 on pop only, unchanged when both happen.
- `o_valid` = (count != 0).
- `o_q` and `o_sat` = `mem[rd_ptr]` fields, FWFT. Their value is don't-care when `o_valid` = 0.
- `o_ready` = (count != DEPTH) & `reset`. It has no combinational path from `i_ready`.
- `o_sat_count` increments on push with sat = 1 and saturates at 0xFFFF.
- Boundary cases:
  - Full with pop: `o_ready` stays 0 in that cycle. No push occurs, so no same-cycle refill when full.
  - Empty with push: no pop is possible (`o_valid` = 0). Data appears next cycle.
  - Simultaneous push and pop at any 0 < count < DEPTH: count unchanged, both pointers advance.
  - Pointer wrap from DEPTH−1 to 0 is seamless. Ordering is strictly FIFO.
- Reset asserted, including mid-operation:
  - `count`, pointers and `o_sat_count` clear immediately.
  - `o_valid` = 0, `o_ready` = 0, `o_count` = 0, `o_sat_count` = 0.
  - `mem` contents are not reset, and all stored entries are discarded.
  - After deassertion, `o_ready` = 1 with the FIFO empty.

## Timing
- Latency from push to visible at head: 1 cycle when empty; otherwise the entry waits behind older entries.
- Throughput: 1 push and 1 pop per cycle sustained.
- `o_ready` reflects the registered `count` only. It falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.
- Conversion is the only combinational logic in the path from `i_y` to memory. No extra pipeline stage.

## Test plan
- Reset then single push: `i_y`=0x0200_0000 (1.0), with `i_ready`=1. Required: next cycle `o_valid`=1, `o_q`=0x4000, `o_sat`=0. Entry popped that cycle; `o_count` returns to 0.
- Rounding and saturation, pushed back-to-back with `i_ready`=0:
  - 0x0200_0400 → `o_q`=0x4001, sat 0.
  - 0x0800_0000 (4.0) → 0xFFFF, sat 1.
  - 0x07FF_FC00 → 0xFFFF, sat 1.
  - 0x07FF_F800 → 0xFFFF, sat 0.
  - Required: `o_sat_count`=2 after these four pushes.
- Fill, DEPTH=8, `i_ready`=0, `i_valid` held 1 with values 1..9 (×2^11):
  - Exactly 8 accepted; `o_ready`=0 with `o_count`=8; the 9th is not accepted while full.
  - Then `i_ready`=1 for one cycle: head value 1 pops, and `o_ready`=1 next cycle.
- Streaming with wrap: 20 pushes and concurrent pops with `i_ready`=1 throughout. Required: `o_count` ≤1, output order equals input order, no drops.
- Reset mid-operation: fill 5 entries, then pull `reset` low asynchronously between clock edges. Required:
  - Immediately: `o_valid`=0, `o_ready`=0, `o_count`=0, `o_sat_count`=0.
  - After release: empty, `o_ready`=1, and the old data never appears.
- Random stress: random `i_valid` and `i_ready` over 10k cycles against a scoreboard model. Required:
  - No loss or reorder, `o_q` matches the conversion model, and `o_count` matches the model count.
  - `o_ready` never asserted while count=DEPTH.
